regfile_multiport: RTL
======================

// Module: regfile_multiport
// PURPOSE
//  Parametrised multi-port register file for the mock-ALU datapath; next generation of the fixed 128x64 8R/4W file.
//  Generalises depth, width and read/write port counts, and keeps per-byte write masks.
//  Adds async reset, registered (1-cycle) reads with valid flags, and defined write-conflict priority.
//  Adds optional same-cycle write-to-read forwarding. Sits between the ALU issue stage and the functional units.
// PARAMETERS
//  DEPTH    128  number of entries (>=2; need not be a power of 2)
//  WIDTH    64   bits per entry; must be a multiple of 8
//  NREAD    8    read ports (>=1)
//  NWRITE   4    write ports (>=1)
//  AW       $clog2(DEPTH)  address width (derived; do not override)
// PORTS
//  clock     in   1             single clock; all state updates on posedge
//  reset_n   in   1             asynchronous, active-low reset
//  rd_en     in   NREAD         per-port read request
//  rd_addr   in   NREAD*AW      port i address at [i*AW +: AW]
//  rd_data   out  NREAD*WIDTH   port i data at [i*WIDTH +: WIDTH]
//  rd_valid  out  NREAD         port i data valid (registered)
//  wr_en     in   NWRITE        per-port write request
//  wr_addr   in   NWRITE*AW     port j address
//  wr_data   in   NWRITE*WIDTH  port j data
//  wr_mask   in   NWRITE*WIDTH/8  port j byte enables; bit b covers byte [8b+7:8b]
// BEHAVIOUR
//  Reset (reset_n low, async):
//   - all DEPTH entries := 0; rd_data := 0; rd_valid := 0.
//   - takes effect mid-operation; requests in the reset cycle are dropped.
//  Write, cycle t:
//   - byte b of entry A updates at posedge t iff some port j has wr_en[j] & wr_mask[j][b] & wr_addr[j]==A.
//   - unmasked bytes are retained.
//  Write conflict: several ports hit the same entry and byte in one cycle -> highest port index wins, per byte.
//   Different bytes of one entry from different ports merge.
//  Read latency is 1:
//   - rd_en[i] sampled at t -> rd_data[i] and rd_valid[i]=1 from posedge t, stable through cycle t+1.
//   - rd_en[i]=0 -> rd_valid[i]=0 next cycle and rd_data[i] holds its previous value (never X).
//  Out-of-range address (addr >= DEPTH, possible only for non-power-of-2 DEPTH):
//   - write ignored.
//   - read returns 0 with rd_valid=1.
//  Read/write same address, same cycle: see CONFIGURATION.
//  All ports are independent; any number may target the same entry.
// CONFIGURATION
//  Macro REGFILE_MULTIPORT_BYPASS_EN:
//   - defined: rd_data for a read at t equals the entry after cycle t's writes, i.e. byte-wise merged new data with conflict priority applied (write-first).
//   - undefined: rd_data equals the entry contents before cycle t's writes (read-first).
//   - In both cases the stored array is identical; only the read-port view differs.
// STRUCTURE
//  Package regfile_multiport_pkg:
//   - byte-lane count constant NBYTES=WIDTH/8.
//   - function merge_bytes(old, new, mask).
//   - function addr_in_range(addr, DEPTH).
//  Sub-module regfile_wr_merge:
//   - combinational per-entry merge of all NWRITE ports with high-index priority.
//   - outputs next-value and a hit flag.
//   - instantiated once per entry; reused by the bypass path when BYPASS_EN is defined.
//  Top-level holds the storage array, the read-mux/output registers and the reset.
// TESTING
//  1. Reset then read all ports at addr 0..NREAD-1 -> rd_data=0, rd_valid=1 one cycle after rd_en.
//  2. W0 writes addr 5, data 64'h1122334455667788, mask 8'h0F; then read 5
//     -> 64'h0000000055667788 (upper bytes keep reset 0).
//  3. Same cycle, W1 and W3 write addr 9 mask 8'hFF, data 64'hAAAA.. and 64'hBBBB..
//     -> read 9 returns 64'hBBBBBBBBBBBBBBBB (W3 wins).
//     W0 mask 8'h01 with W2 mask 8'h80 to addr 10 -> both bytes land.
//  4. Entry 3 = 64'h1; same cycle write 3 <- 64'h2 and read 3:
//     - BYPASS_EN defined -> rd_data = 64'h2.
//     - undefined -> rd_data = 64'h1.
//     - The next read returns 64'h2 in both builds.
//  5. Assert reset_n mid-burst, after several writes and active reads
//     -> rd_valid and rd_data drop to 0 immediately, asynchronously.
//     Post-reset reads of the written entries return 0.
//  6. DEPTH=100: write addr 110 <- 64'hFF, then read 110 -> 0, valid=1, no other entry modified.
//     Also run NREAD=2, NWRITE=1, WIDTH=32 (smoke).

Source files
------------

// File: rtl/regfile_multiport_pkg.sv
// Shared constants and helpers for the multi-port register file.
// Byte lanes are always 8 bits. The actual lane count of an instance is
// computed from its WIDTH parameter with lanes().
package regfile_multiport_pkg;

    localparam int unsigned BYTE_W        = 8;
    localparam int unsigned DEFAULT_WIDTH = 64;
    localparam int unsigned NBYTES        = DEFAULT_WIDTH / BYTE_W;

    // Returns the number of byte lanes in a word of the given width.
    function automatic int unsigned lanes(input int unsigned width);
        return width / BYTE_W;
    endfunction

    // Merges one byte lane: the new byte replaces the old one only when enabled.
    function automatic logic [BYTE_W-1:0] merge_bytes(input logic [BYTE_W-1:0] old_byte,
                                                      input logic [BYTE_W-1:0] new_byte,
                                                      input logic              en);
        return en ? new_byte : old_byte;
    endfunction

    // Returns 1 when the address selects a real entry. This matters for a
    // non-power-of-2 depth.
    function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/regfile_wr_merge.sv
// Combinational write merge for a single register-file entry (address ENTRY).
// All write ports are folded in byte by byte, in ascending port order. A
// higher port index therefore wins a byte conflict. Different bytes written
// by different ports merge.
// The hit output flags that at least one byte of this entry is written.
module regfile_wr_merge
    import regfile_multiport_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int NWRITE = 4,
    parameter int AW     = 7,
    parameter int ENTRY  = 0
) (
    input  logic [WIDTH-1:0]          old_data,
    input  logic [NWRITE-1:0]         wr_en,
    input  logic [NWRITE*AW-1:0]      wr_addr,
    input  logic [NWRITE*WIDTH-1:0]   wr_data,
    input  logic [NWRITE*WIDTH/8-1:0] wr_mask,
    output logic [WIDTH-1:0]          new_data,
    output logic                      hit
);

    localparam int NB = int'(lanes(WIDTH));

    logic [NWRITE-1:0] port_sel;
    logic [NB-1:0]     lane_hit;

    genvar gi;

    // A port takes part in the merge only when it is enabled and addressed to this entry.
    generate
        for (gi = 0; gi < NWRITE; gi++) begin : g_sel
            assign port_sel[gi] = wr_en[gi] && (wr_addr[gi*AW +: AW] == AW'(ENTRY));
        end
    endgenerate

    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            logic [7:0] lane_next;
            logic       lane_wr;

            // Fold ports low to high, so the last enabled port owns the byte.
            always_comb begin
                lane_next = old_data[gi*8 +: 8];
                lane_wr   = 1'b0;
                for (int j = 0; j < NWRITE; j++) begin
                    lane_wr   = lane_wr | (port_sel[j] & wr_mask[j*NB + gi]);
                    lane_next = merge_bytes(lane_next, wr_data[j*WIDTH + gi*8 +: 8],
                                            port_sel[j] & wr_mask[j*NB + gi]);
                end
            end

            assign new_data[gi*8 +: 8] = lane_next;
            assign lane_hit[gi]        = lane_wr;
        end
    endgenerate

    assign hit = |lane_hit;

endmodule

// File: rtl/regfile_multiport.sv
// Parametrised multi-port register file with:
//  - byte-masked writes,
//  - high-index-wins write conflicts,
//  - registered 1-cycle reads with valid flags,
//  - an asynchronous active-low reset.
// Optional macro REGFILE_MULTIPORT_BYPASS_EN makes reads write-first: a read
// sees the same cycle's merged writes. Without it, reads are read-first. The
// stored contents are the same in both builds.
module regfile_multiport
    import regfile_multiport_pkg::*;
#(
    parameter int DEPTH  = 128,
    parameter int WIDTH  = 64,
    parameter int NREAD  = 8,
    parameter int NWRITE = 4,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [NREAD-1:0]          rd_en,
    input  logic [NREAD*AW-1:0]       rd_addr,
    output logic [NREAD*WIDTH-1:0]    rd_data,
    output logic [NREAD-1:0]          rd_valid,
    input  logic [NWRITE-1:0]         wr_en,
    input  logic [NWRITE*AW-1:0]      wr_addr,
    input  logic [NWRITE*WIDTH-1:0]   wr_data,
    input  logic [NWRITE*WIDTH/8-1:0] wr_mask
);

    logic [WIDTH-1:0] mem_reg  [DEPTH];
    logic [WIDTH-1:0] mem_next [DEPTH];
    logic [DEPTH-1:0] entry_hit;

    genvar gi;

    // One merge block per entry. An out-of-range write address matches no
    // entry, so that write is dropped.
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            regfile_wr_merge #(
                .WIDTH  (WIDTH),
                .NWRITE (NWRITE),
                .AW     (AW),
                .ENTRY  (gi)
            ) u_merge (
                .old_data (mem_reg[gi]),
                .wr_en    (wr_en),
                .wr_addr  (wr_addr),
                .wr_data  (wr_data),
                .wr_mask  (wr_mask),
                .new_data (mem_next[gi]),
                .hit      (entry_hit[gi])
            );
        end
    endgenerate

    // Storage update: an entry loads its merged value only when some byte of it is written.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int e = 0; e < DEPTH; e++) mem_reg[e] <= '0;
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                if (entry_hit[e]) mem_reg[e] <= mem_next[e];
            end
        end
    end

    generate
        for (gi = 0; gi < NREAD; gi++) begin : g_rd
            logic [AW-1:0]    addr;
            logic             in_range;
            logic [WIDTH-1:0] rd_word;
            logic [WIDTH-1:0] rd_data_reg;
            logic             rd_valid_reg;

            assign addr     = rd_addr[gi*AW +: AW];
            assign in_range = addr_in_range(32'(addr), DEPTH);
`ifdef REGFILE_MULTIPORT_BYPASS_EN
            assign rd_word  = in_range ? mem_next[addr] : '0;
`else
            assign rd_word  = in_range ? mem_reg[addr] : '0;
`endif

            // Read output register: capture on request; otherwise hold data and clear valid.
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    rd_data_reg  <= '0;
                    rd_valid_reg <= 1'b0;
                end else begin
                    rd_valid_reg <= rd_en[gi];
                    if (rd_en[gi]) rd_data_reg <= rd_word;
                end
            end

            assign rd_data[gi*WIDTH +: WIDTH] = rd_data_reg;
            assign rd_valid[gi]               = rd_valid_reg;
        end
    endgenerate

endmodule
